m21_rr_arbiter: RTL

- Round-robin arbiter that shares the m21 2:1 multiplexer datapath between two requesters.
- Drives the mux select S0 and presents the selected word on Y with a valid/ready handshake toward one downstream consumer.
- Bounds each grant tenure to MAX_HOLD transfers when the other side is waiting, so neither requester is starved.

---
 rtl/m21_rr_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/m21_rr_arbiter.sv
// Round-robin arbiter sharing the m21 2:1 mux between two requesters.
// Each grant tenure is capped at MAX_HOLD beats while the other side waits.
module m21_rr_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             RDY,
  output logic             GNT0,
  output logic             GNT1,
  output logic             S0,
  output logic [WIDTH-1:0] Y,
  output logic             VLD
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt0_d, gnt1_d, s0_d;
  logic             beat;

  // Datapath and handshake are combinational off the registered select/grants
  assign Y    = S0 ? I1 : I0;
  assign VLD  = (GNT0 & REQ0) | (GNT1 & REQ1);
  assign beat = VLD & RDY;

  // Next-state, tenure counter, priority pointer and registered-output inputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    s0_d    = S0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (REQ0 && REQ1) begin
          state_d = last_q ? G0 : G1;
        end else if (REQ0) begin
          state_d = G0;
        end else if (REQ1) begin
          state_d = G1;
        end
      end
      G0: begin
        if (!REQ0) begin
          state_d = REQ1 ? G1 : IDLE;
          cnt_d   = '0;
        end else if (beat) begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d = '0;
            if (REQ1) state_d = G1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      G1: begin
        if (!REQ1) begin
          state_d = REQ0 ? G0 : IDLE;
          cnt_d   = '0;
        end else if (beat) begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d = '0;
            if (REQ0) state_d = G0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Record the owner of every new tenure so the next tie goes the other way
    if (state_d == G0 && state_q != G0) last_d = 1'b0;
    if (state_d == G1 && state_q != G1) last_d = 1'b1;

    gnt0_d = (state_d == G0);
    gnt1_d = (state_d == G1);
    if (state_d == G0) s0_d = 1'b0;
    if (state_d == G1) s0_d = 1'b1;
  end

  // State and output registers; reset drops any in-flight beat
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      GNT0    <= 1'b0;
      GNT1    <= 1'b0;
      S0      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      GNT0    <= gnt0_d;
      GNT1    <= gnt1_d;
      S0      <= s0_d;
    end
  end

endmodule
